// File: rtl/ins_prog_loader_if.sv
// Host load and core fetch signals for ins_prog_loader; the loader uses the slave modport,
// and the host/core side uses the master modport.
interface ins_prog_loader_if #(
  parameter int INS_W  = 19,
  parameter int ADDR_W = 8
) ();
  logic              load_start;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [INS_W-1:0]  ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_err;
  logic [ADDR_W-1:0] ins_addr;
  logic [INS_W-1:0]  ins_out;
  logic              core_enable;

  modport master (
    output load_start, ld_len, ld_valid, ld_data, ins_addr,
    input  ld_ready, ld_done, ld_err, ins_out, core_enable
  );

  modport slave (
    input  load_start, ld_len, ld_valid, ld_data, ins_addr,
    output ld_ready, ld_done, ld_err, ins_out, core_enable
  );
endinterface

// File: rtl/ins_prog_loader.sv
// Writable instruction store: streams a length-checked program in, then releases the core.
// Optional trailing XOR checksum beat when LOADER_CHKSUM_EN is defined.
module ins_prog_loader #(
  parameter int INS_W  = 19,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ins_prog_loader_if.slave  bus_if
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
`ifdef LOADER_CHKSUM_EN
  localparam logic [2:0] CHECK = 3'd2;
`endif
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  logic [2:0]       state_q, state_d;
  logic [ADDR_W:0]  wptr_q, wptr_d;
  logic [ADDR_W:0]  len_q, len_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             en_q, en_d;
  logic             wr_en;
  logic             beat;
  logic             len_ok;
  logic             last_word;
  logic [INS_W-1:0] mem_q [DEPTH];
`ifdef LOADER_CHKSUM_EN
  logic [INS_W-1:0] chk_q, chk_d;
`endif

  assign beat      = bus_if.ld_valid & ready_q;
  assign len_ok    = (bus_if.ld_len != '0) && (bus_if.ld_len <= DEPTH_L);
  assign last_word = (wptr_q == (len_q - ONE_L));

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    len_d   = len_q;
    ready_d = ready_q;
    done_d  = done_q;
    err_d   = err_q;
    en_d    = en_q;
    wr_en   = 1'b0;
`ifdef LOADER_CHKSUM_EN
    chk_d   = chk_q;
`endif
    // A restart wins over everything, including a beat presented in the same cycle.
    if (bus_if.load_start) begin
      wptr_d = '0;
      done_d = 1'b0;
      en_d   = 1'b0;
`ifdef LOADER_CHKSUM_EN
      chk_d  = '0;
`endif
      if (len_ok) begin
        state_d = LOAD;
        len_d   = bus_if.ld_len;
        ready_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        state_d = ERR;
        ready_d = 1'b0;
        err_d   = 1'b1;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (beat) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + ONE_L;
`ifdef LOADER_CHKSUM_EN
            chk_d  = chk_q ^ bus_if.ld_data;
            if (last_word) begin
              state_d = CHECK;
            end
`else
            if (last_word) begin
              state_d = RUN;
              ready_d = 1'b0;
              done_d  = 1'b1;
              en_d    = 1'b1;
            end
`endif
          end
        end
`ifdef LOADER_CHKSUM_EN
        CHECK: begin
          if (beat) begin
            ready_d = 1'b0;
            if (bus_if.ld_data == chk_q) begin
              state_d = RUN;
              done_d  = 1'b1;
              en_d    = 1'b1;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      len_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
`ifdef LOADER_CHKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
`ifdef LOADER_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  // Storage is deliberately not reset; reads stay gated until a full load completes.
  always_ff @(posedge clk_i) begin
    if (wr_en && rst_ni) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= bus_if.ld_data;
    end
  end

  assign bus_if.ins_out     = ((state_q == RUN) && ({1'b0, bus_if.ins_addr} < len_q))
                              ? mem_q[bus_if.ins_addr] : '0;
  assign bus_if.ld_ready    = ready_q;
  assign bus_if.ld_done     = done_q;
  assign bus_if.ld_err      = err_q;
  assign bus_if.core_enable = en_q;

endmodule

// File: tb/tb_ins_prog_loader.sv
// Directed, table-driven bench for ins_prog_loader; covers the checksum path when
// LOADER_CHKSUM_EN is defined.
module tb_ins_prog_loader;

  typedef struct {
    string       name;
    logic        start;
    logic [8:0]  len;
    logic        valid;
    logic [18:0] data;
    logic [7:0]  addr;
    logic        eReady;
    logic        eDone;
    logic        eErr;
    logic        eEn;
    logic [18:0] eOut;
  } vec_t;

  logic clk;
  logic rstN;
  int   checks;
  int   errors;
  vec_t vecs[$];

  ins_prog_loader_if #(.INS_W(19), .ADDR_W(8)) bus ();

  ins_prog_loader #(.INS_W(19), .ADDR_W(8), .DEPTH(256)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(string name, logic start, logic [8:0] len, logic valid,
                                 logic [18:0] data, logic [7:0] addr, logic eReady,
                                 logic eDone, logic eErr, logic eEn, logic [18:0] eOut);
    vec_t v;
    v.name = name;   v.start = start;   v.len = len;     v.valid = valid;
    v.data = data;   v.addr = addr;     v.eReady = eReady; v.eDone = eDone;
    v.eErr = eErr;   v.eEn = eEn;       v.eOut = eOut;
    vecs.push_back(v);
  endfunction

  task automatic cmpVal(string name, logic [18:0] act, logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string name, logic eReady, logic eDone, logic eErr,
                             logic eEn, logic [18:0] eOut);
    cmpVal({name, ".ready"}, 19'(bus.ld_ready), 19'(eReady));
    cmpVal({name, ".done"},  19'(bus.ld_done),  19'(eDone));
    cmpVal({name, ".err"},   19'(bus.ld_err),   19'(eErr));
    cmpVal({name, ".en"},    19'(bus.core_enable), 19'(eEn));
    cmpVal({name, ".out"},   bus.ins_out, eOut);
  endtask

  task automatic applyStimulus(vec_t v);
    bus.load_start = v.start;
    bus.ld_len     = v.len;
    bus.ld_valid   = v.valid;
    bus.ld_data    = v.data;
    bus.ins_addr   = v.addr;
    @(posedge clk);
    #1;
    checkOutput(v.name, v.eReady, v.eDone, v.eErr, v.eEn, v.eOut);
  endtask

  initial begin
    logic [18:0] w3 [5];
    logic [18:0] chk;
    logic        rdy;
    int          nb;
    int          idx;
    int          cyc;

    checks = 0;
    errors = 0;
    rstN = 1'b0;
    bus.load_start = 1'b0;
    bus.ld_len     = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.ins_addr   = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_a0", 1'b0, 1'b0, 1'b0, 1'b0, 19'h0);
    bus.ins_addr = 8'd200;
    #1;
    cmpVal("reset_a200.out", bus.ins_out, 19'h0);
    rstN = 1'b1;

    addVec("start3", 1, 9'd3, 0, 19'h0,     8'd0, 1, 0, 0, 0, 19'h0);
    addVec("w0",     0, 9'd0, 1, 19'h7A123, 8'd0, 1, 0, 0, 0, 19'h0);
    addVec("w1",     0, 9'd0, 1, 19'h40001, 8'd0, 1, 0, 0, 0, 19'h0);
`ifdef LOADER_CHKSUM_EN
    addVec("w2",     0, 9'd0, 1, 19'h2C0C5, 8'd0, 1, 0, 0, 0, 19'h0);
    addVec("chk3",   0, 9'd0, 1, 19'h161E7, 8'd0, 0, 1, 0, 1, 19'h7A123);
`else
    addVec("w2",     0, 9'd0, 1, 19'h2C0C5, 8'd0, 0, 1, 0, 1, 19'h7A123);
`endif
    addVec("rd1",    0, 9'd0, 0, 19'h0, 8'd1,   0, 1, 0, 1, 19'h40001);
    addVec("rd2",    0, 9'd0, 0, 19'h0, 8'd2,   0, 1, 0, 1, 19'h2C0C5);
    addVec("rd3",    0, 9'd0, 0, 19'h0, 8'd3,   0, 1, 0, 1, 19'h0);
    addVec("rd255",  0, 9'd0, 0, 19'h0, 8'd255, 0, 1, 0, 1, 19'h0);
    addVec("len0",   1, 9'd0, 0, 19'h0, 8'd0,   0, 0, 1, 0, 19'h0);
    addVec("errhold",0, 9'd0, 1, 19'h12345, 8'd0, 0, 0, 1, 0, 19'h0);
    addVec("len257", 1, 9'd257, 0, 19'h0, 8'd0, 0, 0, 1, 0, 19'h0);
    addVec("len256", 1, 9'd256, 0, 19'h0, 8'd0, 1, 0, 0, 0, 19'h0);
    addVec("len1",   1, 9'd1, 0, 19'h0, 8'd0,   1, 0, 0, 0, 19'h0);
`ifdef LOADER_CHKSUM_EN
    addVec("w1only", 0, 9'd0, 1, 19'h11111, 8'd0, 1, 0, 0, 0, 19'h0);
    addVec("chk1",   0, 9'd0, 1, 19'h11111, 8'd0, 0, 1, 0, 1, 19'h11111);
`else
    addVec("w1only", 0, 9'd0, 1, 19'h11111, 8'd0, 0, 1, 0, 1, 19'h11111);
`endif
    addVec("rdOut1", 0, 9'd0, 0, 19'h0, 8'd1,   0, 1, 0, 1, 19'h0);
    addVec("restart",1, 9'd2, 1, 19'h55555, 8'd0, 1, 0, 0, 0, 19'h0);
    addVec("nw0",    0, 9'd0, 1, 19'h0AAAA, 8'd0, 1, 0, 0, 0, 19'h0);
`ifdef LOADER_CHKSUM_EN
    addVec("nw1",    0, 9'd0, 1, 19'h03333, 8'd0, 1, 0, 0, 0, 19'h0);
    addVec("nchk",   0, 9'd0, 1, 19'h09999, 8'd0, 0, 1, 0, 1, 19'h0AAAA);
`else
    addVec("nw1",    0, 9'd0, 1, 19'h03333, 8'd0, 0, 1, 0, 1, 19'h0AAAA);
`endif
    addVec("nrd1",   0, 9'd0, 0, 19'h0, 8'd1,   0, 1, 0, 1, 19'h03333);
`ifdef LOADER_CHKSUM_EN
    addVec("gStart", 1, 9'd2, 0, 19'h0, 8'd0,     1, 0, 0, 0, 19'h0);
    addVec("gW0",    0, 9'd0, 1, 19'h00F0F, 8'd0, 1, 0, 0, 0, 19'h0);
    addVec("gW1",    0, 9'd0, 1, 19'h0F0F0, 8'd0, 1, 0, 0, 0, 19'h0);
    addVec("gChk",   0, 9'd0, 1, 19'h0FFFF, 8'd0, 0, 1, 0, 1, 19'h00F0F);
    addVec("bStart", 1, 9'd2, 0, 19'h0, 8'd0,     1, 0, 0, 0, 19'h0);
    addVec("bW0",    0, 9'd0, 1, 19'h00F0F, 8'd0, 1, 0, 0, 0, 19'h0);
    addVec("bW1",    0, 9'd0, 1, 19'h0F0F0, 8'd0, 1, 0, 0, 0, 19'h0);
    addVec("bChk",   0, 9'd0, 1, 19'h0FFFE, 8'd0, 0, 0, 1, 0, 19'h0);
`endif

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Backpressure load: random valid, host holds each word until it is taken.
    w3[0] = 19'h12345; w3[1] = 19'h6789A; w3[2] = 19'h00001; w3[3] = 19'h7FFFF;
    chk = w3[0] ^ w3[1] ^ w3[2] ^ w3[3];
    w3[4] = chk;
`ifdef LOADER_CHKSUM_EN
    nb = 5;
`else
    nb = 4;
`endif
    bus.load_start = 1'b1; bus.ld_len = 9'd4; bus.ld_valid = 1'b0; bus.ins_addr = 8'd0;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
    checkOutput("bpStart", 1'b1, 1'b0, 1'b0, 1'b0, 19'h0);
    idx = 0;
    cyc = 0;
    while (idx < nb && cyc < 200) begin
      bus.ld_valid = 1'($urandom_range(0, 1));
      bus.ld_data  = w3[idx];
      rdy = bus.ld_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.ld_valid && rdy) idx++;
      cmpVal("bpReady", 19'(bus.ld_ready), 19'(idx < nb));
      cmpVal("bpEn", 19'(bus.core_enable), 19'(idx == nb));
    end
    if (idx < nb) begin
      errors++;
      $display("[TB] FAIL bpTimeout: accepted %0d beats expected %0d", idx, nb);
    end
    bus.ld_valid = 1'b1;
    bus.ld_data  = 19'h3ABCD;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    checkOutput("bpRun", 1'b0, 1'b1, 1'b0, 1'b1, w3[0]);
    for (int a = 1; a < 5; a++) begin
      bus.ins_addr = 8'(a);
      #1;
      cmpVal($sformatf("bpRd%0d", a), bus.ins_out, (a < 4) ? w3[a] : 19'h0);
    end

    // Reset in the middle of a load leaves the core held and reads gated.
    bus.load_start = 1'b1; bus.ld_len = 9'd4; bus.ins_addr = 8'd0;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 19'h01234;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutput("midReset", 1'b0, 1'b0, 1'b0, 1'b0, 19'h0);
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    checkOutput("idleValid", 1'b0, 1'b0, 1'b0, 1'b0, 19'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
